// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised multi-read, single-write register file with
// per-register pending (scoreboard) bits. Register 0 is hardwired to zero.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module regfile_scoreboard #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] rdata,
    output logic [NREAD-1:0]       rpend,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic                   rsv_dup,
    output logic [AW:0]            pend_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0]       r_regs [1:DEPTH-1];
    logic [DEPTH-1:0]       r_pend;
    logic                   r_rsv_dup;
    logic [CW-1:0]          r_pend_cnt;

    logic                   w_wr_ok;
    logic                   w_rsv_ok;
    logic [DEPTH-1:0]       w_wr_hit;
    logic [DEPTH-1:0]       w_rsv_hit;
    logic [DEPTH-1:0]       w_pend_nxt;
    logic                   w_dup_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [NREAD*WIDTH-1:0] w_rdata;
    logic [NREAD-1:0]       w_rpend;

    // Address 0 and addresses at or beyond DEPTH are silently dropped
    assign w_wr_ok  = we && (waddr != '0) && (32'(waddr) < DEPTH);
    assign w_rsv_ok = rsv_en && (rsv_addr != '0) && (32'(rsv_addr) < DEPTH);

    // One-hot decode of the write and reserve targets
    always_comb begin
        w_wr_hit  = '0;
        w_rsv_hit = '0;
        for (int k = 1; k < int'(DEPTH); k++) begin
            w_wr_hit[k]  = w_wr_ok  && (waddr    == AW'(k));
            w_rsv_hit[k] = w_rsv_ok && (rsv_addr == AW'(k));
        end
    end

    // Next pending state: writeback clears, reserve sets and wins on a tie
    always_comb begin
        w_pend_nxt = (r_pend & ~w_wr_hit) | w_rsv_hit;
        w_dup_nxt  = |(w_rsv_hit & r_pend & ~w_wr_hit);
        w_cnt_nxt  = '0;
        for (int k = 1; k < int'(DEPTH); k++) begin
            w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[k]);
        end
    end

    // Asynchronous read mux per port, with optional same-cycle write forwarding
    always_comb begin
        logic [AW-1:0] ra;
        w_rdata = '0;
        w_rpend = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            ra = raddr[i*AW +: AW];
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (ra == AW'(k)) begin
                    w_rdata[i*WIDTH +: WIDTH] = r_regs[k];
                    w_rpend[i]                = r_pend[k];
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && (ra == waddr)) begin
                w_rdata[i*WIDTH +: WIDTH] = wdata;
                w_rpend[i]                = w_rsv_ok && (rsv_addr == waddr);
            end
`endif
        end
        // Keep forwarded write data from leaking out while reset is held
        if (!reset_n) begin
            w_rdata = '0;
            w_rpend = '0;
        end
    end

    // State update: register array, pending bits, duplicate pulse, population count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend     <= '0;
            r_rsv_dup  <= 1'b0;
            r_pend_cnt <= '0;
            for (int k = 1; k < int'(DEPTH); k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_pend     <= w_pend_nxt;
            r_rsv_dup  <= w_dup_nxt;
            r_pend_cnt <= w_cnt_nxt;
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (w_wr_hit[k]) begin
                    r_regs[k] <= wdata;
                end
            end
        end
    end

    assign rdata    = w_rdata;
    assign rpend    = w_rpend;
    assign rsv_dup  = r_rsv_dup;
    assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default configuration (32x32, 2 ports)
// plus a 16-bit, 24-entry, 3-port instance for out-of-range address handling.
module tb_regfile_scoreboard;

    logic clk;
    logic reset_n;

    // Instance A: WIDTH=32, DEPTH=32, NREAD=2 (AW=5)
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rpend;
    logic        a_rsv_en;
    logic [4:0]  a_rsv_addr;
    logic        a_rsv_dup;
    logic [5:0]  a_pend_cnt;

    // Instance B: WIDTH=16, DEPTH=24, NREAD=3 (AW=5)
    logic        b_we;
    logic [4:0]  b_waddr;
    logic [15:0] b_wdata;
    logic [14:0] b_raddr;
    logic [47:0] b_rdata;
    logic [2:0]  b_rpend;
    logic        b_rsv_en;
    logic [4:0]  b_rsv_addr;
    logic        b_rsv_dup;
    logic [5:0]  b_pend_cnt;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .NREAD(2)) u_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (a_we),
        .waddr    (a_waddr),
        .wdata    (a_wdata),
        .raddr    (a_raddr),
        .rdata    (a_rdata),
        .rpend    (a_rpend),
        .rsv_en   (a_rsv_en),
        .rsv_addr (a_rsv_addr),
        .rsv_dup  (a_rsv_dup),
        .pend_cnt (a_pend_cnt)
    );

    regfile_scoreboard #(.WIDTH(16), .DEPTH(24), .NREAD(3)) u_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (b_we),
        .waddr    (b_waddr),
        .wdata    (b_wdata),
        .raddr    (b_raddr),
        .rdata    (b_rdata),
        .rpend    (b_rpend),
        .rsv_en   (b_rsv_en),
        .rsv_addr (b_rsv_addr),
        .rsv_dup  (b_rsv_dup),
        .pend_cnt (b_pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards land on the following edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0; a_rsv_en = 1'b0; a_rsv_addr = '0;
        b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0; b_rsv_en = 1'b0; b_rsv_addr = '0;

        // Reset state before any clock edge
        #1;
        chk("rst_cnt_noedge", 64'(a_pend_cnt), 64'd0);
        chk("rst_dup_noedge", 64'(a_rsv_dup), 64'd0);
        chk("rst_rdata_noedge", a_rdata, 64'd0);
        chk("rst_rpend_noedge", 64'(a_rpend), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Every address reads zero after reset
        for (int a = 0; a < 32; a++) begin
            a_raddr = {5'(31 - a), 5'(a)};
            #1;
            chk("rst_read_all", a_rdata, 64'd0);
            chk("rst_rpend_all", 64'(a_rpend), 64'd0);
        end

        // Write r5 and r31, read both ports
        a_raddr = '0;
        a_we = 1'b1; a_waddr = 5'd5;  a_wdata = 32'hDEADBEEF;
        tick();
        a_waddr = 5'd31; a_wdata = 32'h12345678;
        tick();
        a_we = 1'b0;
        a_raddr = {5'd31, 5'd5};
        #1;
        chk("rd_p0_r5", 64'(a_rdata[31:0]), 64'hDEADBEEF);
        chk("rd_p1_r31", 64'(a_rdata[63:32]), 64'h12345678);

        // Write to r0 is ignored
        a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFFFFFF;
        tick();
        a_we = 1'b0;
        a_raddr = {5'd0, 5'd0};
        #1;
        chk("r0_zero", a_rdata, 64'd0);

        // Reserve r7
        a_raddr = {5'd7, 5'd5};
        a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
        #1;
        chk("rsv7_pre_edge", 64'(a_rpend[1]), 64'd0);
        tick();
        a_rsv_en = 1'b0;
        chk("rsv7_rpend", 64'(a_rpend[1]), 64'd1);
        chk("rsv7_cnt", 64'(a_pend_cnt), 64'd1);
        chk("rsv7_nodup", 64'(a_rsv_dup), 64'd0);

        // Duplicate reserve of r7
        a_rsv_en = 1'b1;
        tick();
        a_rsv_en = 1'b0;
        chk("dup_pulse", 64'(a_rsv_dup), 64'd1);
        chk("dup_cnt", 64'(a_pend_cnt), 64'd1);
        chk("dup_rpend", 64'(a_rpend[1]), 64'd1);
        tick();
        chk("dup_one_cycle", 64'(a_rsv_dup), 64'd0);

        // Writeback of r7 clears pending
        a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h000000A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wb7_same_data", 64'(a_rdata[63:32]), 64'h000000A5);
        chk("wb7_same_pend", 64'(a_rpend[1]), 64'd0);
`else
        chk("wb7_same_data", 64'(a_rdata[63:32]), 64'd0);
        chk("wb7_same_pend", 64'(a_rpend[1]), 64'd1);
`endif
        tick();
        a_we = 1'b0;
        chk("wb7_data", 64'(a_rdata[63:32]), 64'h000000A5);
        chk("wb7_rpend", 64'(a_rpend[1]), 64'd0);
        chk("wb7_cnt", 64'(a_pend_cnt), 64'd0);

        // Simultaneous write and reserve of r9: reserve wins
        a_raddr = {5'd5, 5'd9};
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h00000055;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
        tick();
        a_we = 1'b0; a_rsv_en = 1'b0;
        chk("wr_rsv9_data", 64'(a_rdata[31:0]), 64'h00000055);
        chk("wr_rsv9_pend", 64'(a_rpend[0]), 64'd1);
        chk("wr_rsv9_cnt", 64'(a_pend_cnt), 64'd1);
        chk("wr_rsv9_dup", 64'(a_rsv_dup), 64'd0);

        // Re-reserve of pending r9 while it is being written: no duplicate
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h00000066;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
        tick();
        a_we = 1'b0; a_rsv_en = 1'b0;
        chk("wr_rsv9b_dup", 64'(a_rsv_dup), 64'd0);
        chk("wr_rsv9b_cnt", 64'(a_pend_cnt), 64'd1);
        chk("wr_rsv9b_data", 64'(a_rdata[31:0]), 64'h00000066);

        // Make r3 pending, then write it while reading it
        a_rsv_en = 1'b1; a_rsv_addr = 5'd3;
        tick();
        a_rsv_en = 1'b0;
        chk("rsv3_cnt", 64'(a_pend_cnt), 64'd2);
        a_raddr = {5'd9, 5'd3};
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h00000077;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp3_data", 64'(a_rdata[31:0]), 64'h00000077);
        chk("byp3_pend", 64'(a_rpend[0]), 64'd0);
`else
        chk("byp3_data", 64'(a_rdata[31:0]), 64'd0);
        chk("byp3_pend", 64'(a_rpend[0]), 64'd1);
`endif
        tick();
        a_we = 1'b0;
        chk("wb3_data", 64'(a_rdata[31:0]), 64'h00000077);
        chk("wb3_pend", 64'(a_rpend[0]), 64'd0);
        chk("wb3_cnt", 64'(a_pend_cnt), 64'd1);

        // Write and reserve r3 together while reading it
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h00000088;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp3r_data", 64'(a_rdata[31:0]), 64'h00000088);
        chk("byp3r_pend", 64'(a_rpend[0]), 64'd1);
`else
        chk("byp3r_data", 64'(a_rdata[31:0]), 64'h00000077);
        chk("byp3r_pend", 64'(a_rpend[0]), 64'd0);
`endif
        tick();
        a_we = 1'b0; a_rsv_en = 1'b0;
        chk("wr_rsv3_data", 64'(a_rdata[31:0]), 64'h00000088);
        chk("wr_rsv3_pend", 64'(a_rpend[0]), 64'd1);
        chk("wr_rsv3_cnt", 64'(a_pend_cnt), 64'd2);

        // Write r9 and reserve r12 in the same cycle
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h00000011;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd12;
        tick();
        a_we = 1'b0; a_rsv_en = 1'b0;
        a_raddr = {5'd12, 5'd9};
        #1;
        chk("split_r9_data", 64'(a_rdata[31:0]), 64'h00000011);
        chk("split_r9_pend", 64'(a_rpend[0]), 64'd0);
        chk("split_r12_pend", 64'(a_rpend[1]), 64'd1);
        chk("split_cnt", 64'(a_pend_cnt), 64'd2);

        // Both ports addressing the same register
        a_raddr = {5'd5, 5'd5};
        #1;
        chk("same_reg_ports", a_rdata, {32'hDEADBEEF, 32'hDEADBEEF});

        // Asynchronous reset mid-operation, with a write pending on the bus
        a_raddr = {5'd3, 5'd5};
        a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'hCAFEF00D;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rdata", a_rdata, 64'd0);
        chk("mid_rst_rpend", 64'(a_rpend), 64'd0);
        chk("mid_rst_cnt", 64'(a_pend_cnt), 64'd0);
        chk("mid_rst_dup", 64'(a_rsv_dup), 64'd0);
        a_we = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_r5", 64'(a_rdata[31:0]), 64'd0);
        chk("post_rst_r3", 64'(a_rdata[63:32]), 64'd0);

        // Instance B: top valid register and out-of-range addresses
        b_we = 1'b1; b_waddr = 5'd23; b_wdata = 16'hBEEF;
        tick();
        b_we = 1'b0;
        b_raddr = {5'd23, 5'd0, 5'd25};
        #1;
        chk("b_r23", 64'(b_rdata[47:32]), 64'hBEEF);
        chk("b_oor_rd", 64'(b_rdata[31:0]), 64'd0);
        chk("b_oor_rpend", 64'(b_rpend), 64'd0);

        b_we = 1'b1; b_waddr = 5'd25; b_wdata = 16'h1234;
        tick();
        b_we = 1'b0;
        chk("b_oor_wr_ign", 64'(b_rdata[15:0]), 64'd0);
        chk("b_r23_intact", 64'(b_rdata[47:32]), 64'hBEEF);

        b_rsv_en = 1'b1; b_rsv_addr = 5'd25;
        tick();
        chk("b_oor_rsv_cnt", 64'(b_pend_cnt), 64'd0);
        chk("b_oor_rsv_dup", 64'(b_rsv_dup), 64'd0);
        tick();
        b_rsv_en = 1'b0;
        chk("b_oor_rsv2_dup", 64'(b_rsv_dup), 64'd0);

        b_rsv_en = 1'b1; b_rsv_addr = 5'd23;
        tick();
        b_rsv_addr = 5'd30;
        tick();
        b_rsv_en = 1'b0;
        chk("b_rsv23_cnt", 64'(b_pend_cnt), 64'd1);
        chk("b_rsv23_rpend", 64'(b_rpend), 64'b100);
        chk("b_oor30_nodup", 64'(b_rsv_dup), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
